game_input_ctrl: RTL and testbench
==================================

Name: game_input_ctrl

Overview:
Upstream front end of the gameplay engine. It synchronises and debounces the four raw push-buttons and generates the 60 Hz new_frame tick. Level inputs are presented frame-aligned, so gameplay sees values that stay stable for a whole frame. new_game is issued as a one-cycle pulse that also restarts the frame timer.

Parameters:
FRAME_CYCLES, 1_666_667, clk_in cycles per frame (100 MHz / 60 Hz).
DEBOUNCE_CYCLES, 1_000_000, consecutive cycles a changed synced level must persist before it is accepted (10 ms).
FRAME_CNT_W, 16, width of frame_count_out.

Ports:
clk_in  input  1  system clock, 100 MHz
rst_in  input  1  synchronous, active-high reset
btn_in  input  4  raw async buttons: [0] new_game, [1] hit, [2] pan_left, [3] pan_right
new_game_out  output  1  one-cycle pulse on debounced new_game press
charging_hit_out  output  1  frame-latched debounced hit level
camera_pan_left_out  output  1  frame-latched pan-left level
camera_pan_right_out  output  1  frame-latched pan-right level
new_frame_out  output  1  one-cycle frame tick
frame_count_out  output  FRAME_CNT_W  frames since last new_game, wraps

Behaviour:
- Clocking and reset: one clock domain, clk_in. rst_in is synchronous and active-high. On reset, all outputs, sync flops, debounce counters, stable levels, frame counter and frame_count_out go to 0.
- Synchroniser: two flops per button. Debounce latency is measured from the output of the second flop.
- Debounce, per button:
  - cnt resets to 0 whenever sync == stable.
  - Otherwise cnt increments.
  - When cnt == DEBOUNCE_CYCLES-1 and sync != stable, stable <= sync and cnt <= 0.
  - A clean edge on btn_in therefore reaches stable after 2 + DEBOUNCE_CYCLES edges.
- Frame timer:
  - fcnt counts 0..FRAME_CYCLES-1.
  - On the edge where fcnt == FRAME_CYCLES-1: fcnt <= 0, new_frame_out <= 1 (high for exactly one cycle), frame_count_out <= frame_count_out+1 (wraps all-ones to 0).
  - On that same edge the level outputs latch the stable values, so they change in the same cycle new_frame_out is high.
  - First pulse is high FRAME_CYCLES edges after rst_in deasserts.
- Pan conflict: if stable pan_left and pan_right are both 1 at the latch, both outputs latch 0.
- new_game:
  - A rising edge of stable new_game produces new_game_out = 1 for one cycle. This is not frame-aligned.
  - On that edge, fcnt <= 0, frame_count_out <= 0, and all three level outputs <= 0.
  - A held button gives exactly one pulse. Release produces nothing.
- Simultaneous new_game edge and frame wrap: new_game wins. No new_frame_out that cycle, frame_count_out = 0, next frame pulse FRAME_CYCLES edges later.
- Level outputs never change except at a frame latch, new_game or reset.
- rst_in mid-debounce or mid-frame: all state is discarded. A button still held after reset is re-accepted only after the full sync + debounce delay, then appears at the next frame latch.

Decomposition:
- Package game_input_pkg:
  - button index localparams BTN_NEW_GAME=0, BTN_HIT=1, BTN_PAN_L=2, BTN_PAN_R=3;
  - default FRAME_CYCLES and DEBOUNCE_CYCLES constants, shared with gameplay and the testbenches.
- Sub-module debouncer (sync + counter, one bit, parameter DEBOUNCE_CYCLES), instantiated four times in a generate loop.
- Frame timer and latch logic live in the top.

Test Plan (FRAME_CYCLES=100, DEBOUNCE_CYCLES=8, FRAME_CNT_W=4):
1. Reset for 3 cycles, then release with no buttons -> new_frame_out single-cycle pulses 100, 200, 300 edges after release; frame_count_out = 1, 2, 3; all levels 0. Run past 16 frames -> frame_count_out wraps 15 -> 0.
2. btn_in[1] toggles every 3 cycles for 30 cycles, then holds 1 -> stable hit rises exactly 10 edges after the last toggle; charging_hit_out rises only at the next new_frame_out cycle and holds between frames.
3. btn_in[2] and btn_in[3] both held -> both pan outputs 0 at every frame; release [2] -> camera_pan_right_out = 1 at the first frame latch after debounce.
4. Press btn_in[0] at fcnt = 50 and hold 500 cycles -> exactly one new_game_out pulse 10 edges later; frame_count_out = 0; levels 0; next new_frame_out 100 edges after the pulse.
5. Time the new_game stable edge to coincide with fcnt = 99 -> no new_frame_out that cycle; frame_count_out = 0; next pulse 100 edges later.
6. Hold hit, then assert rst_in at fcnt = 40 -> all outputs 0 the next cycle; charging_hit_out returns at the first frame latch at least 10 edges after release (frame 1, edge 100).

Source files
------------

// File: rtl/game_input_pkg.sv
// Shared constants for the gameplay input front end: button indices and
// default timing for a 100 MHz clock.
package game_input_pkg;

    localparam int BTN_NEW_GAME = 0;
    localparam int BTN_HIT      = 1;
    localparam int BTN_PAN_L    = 2;
    localparam int BTN_PAN_R    = 3;
    localparam int NUM_BTN      = 4;

    localparam int unsigned FRAME_CYCLES_DEF    = 1_666_667;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;

    typedef struct packed {
        logic hit;
        logic pan_l;
        logic pan_r;
    } levels_t;

endpackage

// File: rtl/debouncer.sv
// One-bit button conditioner: two-flop synchroniser followed by a
// persistence counter that accepts a new level after DEBOUNCE_CYCLES cycles.
module debouncer
    import game_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic raw,
    output logic stable,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    // rise is asserted on the same edge that stable takes the new value
    assign accept = (sync_2 != stable) && (cnt == CNT_LAST);
    assign rise   = accept && sync_2;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            if (sync_2 == stable) begin
                cnt <= '0;
            end else if (accept) begin
                stable <= sync_2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/game_input_ctrl.sv
// Input front end: debounces the four buttons, generates the frame tick and
// presents frame-aligned level outputs plus a new_game pulse.
module game_input_ctrl
    import game_input_pkg::*;
#(
    parameter int unsigned FRAME_CYCLES    = FRAME_CYCLES_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned FRAME_CNT_W     = 16
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [NUM_BTN-1:0]     btn_in,
    output logic                   new_game_out,
    output logic                   charging_hit_out,
    output logic                   camera_pan_left_out,
    output logic                   camera_pan_right_out,
    output logic                   new_frame_out,
    output logic [FRAME_CNT_W-1:0] frame_count_out
);

    localparam int FCNT_W = $clog2(FRAME_CYCLES + 1);
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAME_CYCLES - 1);

    logic [NUM_BTN-1:0] stable;
    logic [NUM_BTN-1:0] rise;
    logic [FCNT_W-1:0]  fcnt;
    levels_t            levels;
    levels_t            frame_levels;
    logic               ng_rise;
    logic               frame_wrap;
    logic               unused_rise;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debouncer (
            .clk_in (clk_in),
            .rst_in (rst_in),
            .raw    (btn_in[i]),
            .stable (stable[i]),
            .rise   (rise[i])
        );
    end

    // Only the new_game button needs an edge; the others are sampled as levels.
    assign ng_rise     = rise[BTN_NEW_GAME];
    assign unused_rise = ^rise[BTN_PAN_R:BTN_HIT];
    assign frame_wrap  = (fcnt == FCNT_LAST);

    // Opposing pan requests cancel rather than favouring one direction.
    always_comb begin
        frame_levels       = '0;
        frame_levels.hit   = stable[BTN_HIT];
        frame_levels.pan_l = stable[BTN_PAN_L] & ~stable[BTN_PAN_R];
        frame_levels.pan_r = stable[BTN_PAN_R] & ~stable[BTN_PAN_L];
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            fcnt            <= '0;
            new_game_out    <= 1'b0;
            new_frame_out   <= 1'b0;
            frame_count_out <= '0;
            levels          <= '0;
        end else begin
            new_game_out  <= ng_rise;
            new_frame_out <= 1'b0;
            if (ng_rise) begin
                fcnt            <= '0;
                frame_count_out <= '0;
                levels          <= '0;
            end else if (frame_wrap) begin
                fcnt            <= '0;
                new_frame_out   <= 1'b1;
                frame_count_out <= frame_count_out + FRAME_CNT_W'(1);
                levels          <= frame_levels;
            end else begin
                fcnt <= fcnt + FCNT_W'(1);
            end
        end
    end

    assign charging_hit_out     = levels.hit;
    assign camera_pan_left_out  = levels.pan_l;
    assign camera_pan_right_out = levels.pan_r;

endmodule

// File: tb/tb_game_input_ctrl.sv
// Scoreboard bench for game_input_ctrl: a window-based reference model
// predicts every pulse and its payload; a monitor checks what the DUT shows.
module tb_game_input_ctrl;
    import game_input_pkg::*;

    localparam int FC = 100;
    localparam int DC = 8;
    localparam int FW = 4;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic [3:0]    btn_in = 4'b0;
    logic          new_game_out;
    logic          charging_hit_out;
    logic          camera_pan_left_out;
    logic          camera_pan_right_out;
    logic          new_frame_out;
    logic [FW-1:0] frame_count_out;

    game_input_ctrl #(
        .FRAME_CYCLES(FC),
        .DEBOUNCE_CYCLES(DC),
        .FRAME_CNT_W(FW)
    ) dut (
        .clk_in               (clk_in),
        .rst_in               (rst_in),
        .btn_in               (btn_in),
        .new_game_out         (new_game_out),
        .charging_hit_out     (charging_hit_out),
        .camera_pan_left_out  (camera_pan_left_out),
        .camera_pan_right_out (camera_pan_right_out),
        .new_frame_out        (new_frame_out),
        .frame_count_out      (frame_count_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int            edge_n;
        logic          is_ng;
        logic [FW-1:0] fcount;
        logic [2:0]    lv;
    } ev_t;

    ev_t  exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   edge_cnt = 0;
    logic rst_q = 1'b1;

    always @(posedge clk_in) begin
        edge_cnt <= edge_cnt + 1;
        rst_q    <= rst_in;
    end

    // Reference model state: synchroniser pipeline, window of synced samples
    logic [3:0] m_s1 = '0;
    logic [3:0] m_s2 = '0;
    logic [3:0] m_stable = '0;
    logic [3:0] m_hist[$];
    int         m_restart = 0;
    int         m_n = 0;

    // A button is accepted once the last DC synced samples all disagree with
    // its stable level; frames fall every FC edges after the latest restart.
    task automatic model_step(input logic [3:0] b, input logic r);
        int         n;
        logic [3:0] acc;
        logic [3:0] nxt;
        logic       all_diff;
        ev_t        e;
        n   = edge_cnt + 1;
        m_n = n;
        if (r) begin
            m_s1 = '0;
            m_s2 = '0;
            m_stable = '0;
            m_hist.delete();
            m_restart = n;
            return;
        end
        m_hist.push_back(m_s2);
        if (m_hist.size() > DC) void'(m_hist.pop_front());
        acc = '0;
        for (int bi = 0; bi < NUM_BTN; bi++) begin
            all_diff = (m_hist.size() == DC);
            foreach (m_hist[k]) if (m_hist[k][bi] == m_stable[bi]) all_diff = 1'b0;
            acc[bi] = all_diff;
        end
        nxt = m_stable ^ acc;
        if (acc[0] && nxt[0]) begin
            e.edge_n = n; e.is_ng = 1'b1; e.fcount = '0; e.lv = '0;
            exp_q.push_back(e);
            m_restart = n;
        end else if ((n - m_restart) % FC == 0) begin
            e.edge_n = n;
            e.is_ng  = 1'b0;
            e.fcount = FW'((n - m_restart) / FC);
            e.lv     = {m_stable[1], m_stable[2] & ~m_stable[3], m_stable[3] & ~m_stable[2]};
            exp_q.push_back(e);
        end
        m_stable = nxt;
        m_s2 = m_s1;
        m_s1 = b;
    endtask

    task automatic cycle(input logic [3:0] b, input logic r);
        @(negedge clk_in);
        btn_in = b;
        rst_in = r;
        model_step(b, r);
    endtask

    // Idle with b held until the next edge sits at frame phase ph.
    task automatic wait_phase(input logic [3:0] b, input int ph);
        for (int i = 0; i < FC; i++) begin
            if ((m_n + 1 - m_restart) % FC == ph) break;
            cycle(b, 1'b0);
        end
    endtask

    initial begin : monitor
        ev_t           e;
        logic [2:0]    cur_lv;
        logic [2:0]    prev_lv;
        logic [FW-1:0] prev_fc;
        prev_lv = '0;
        prev_fc = '0;
        forever begin
            @(negedge clk_in);
            cur_lv = {charging_hit_out, camera_pan_left_out, camera_pan_right_out};
            while (exp_q.size() > 0 && exp_q[0].edge_n < edge_cnt) begin
                e = exp_q.pop_front();
                tests++;
                fails++;
                $display("FAIL missed_pulse edge=%0d ng=%0b: got no pulse, want one", e.edge_n, e.is_ng);
            end
            if (rst_q) begin
                tests++;
                if ({new_game_out, new_frame_out, cur_lv, frame_count_out} != '0) begin
                    fails++;
                    $display("FAIL reset_state edge=%0d got ng=%0b nf=%0b lv=%b fc=%0d want all 0",
                             edge_cnt, new_game_out, new_frame_out, cur_lv, frame_count_out);
                end
            end else if (new_frame_out || new_game_out) begin
                tests++;
                if (exp_q.size() == 0 || exp_q[0].edge_n != edge_cnt) begin
                    fails++;
                    $display("FAIL unexpected_pulse edge=%0d got ng=%0b nf=%0b want no pulse (next expected edge=%0d)",
                             edge_cnt, new_game_out, new_frame_out,
                             (exp_q.size() > 0) ? exp_q[0].edge_n : -1);
                end else begin
                    e = exp_q.pop_front();
                    if (new_game_out != e.is_ng || new_frame_out == e.is_ng ||
                        frame_count_out != e.fcount || cur_lv != e.lv) begin
                        fails++;
                        $display("FAIL pulse_content edge=%0d got ng=%0b nf=%0b fc=%0d lv=%b want ng=%0b nf=%0b fc=%0d lv=%b",
                                 edge_cnt, new_game_out, new_frame_out, frame_count_out, cur_lv,
                                 e.is_ng, !e.is_ng, e.fcount, e.lv);
                    end
                end
            end else begin
                tests++;
                if (cur_lv != prev_lv || frame_count_out != prev_fc) begin
                    fails++;
                    $display("FAIL hold_between_frames edge=%0d got lv=%b fc=%0d want lv=%b fc=%0d",
                             edge_cnt, cur_lv, frame_count_out, prev_lv, prev_fc);
                end
            end
            prev_lv = cur_lv;
            prev_fc = frame_count_out;
        end
    end

    initial begin : stimulus
        logic [3:0] b;
        int         hold;
        repeat (3) cycle(4'b0000, 1'b1);
        // idle past 16 frames to see the counter wrap
        repeat (17 * FC + 20) cycle(4'b0000, 1'b0);
        // bouncing hit, then held
        for (int i = 0; i < 10; i++) repeat (3) cycle({2'b00, i[0], 1'b0}, 1'b0);
        repeat (300) cycle(4'b0010, 1'b0);
        repeat (30) cycle(4'b0000, 1'b0);
        // conflicting pans, then right alone
        repeat (300) cycle(4'b1100, 1'b0);
        repeat (300) cycle(4'b1000, 1'b0);
        repeat (50) cycle(4'b0000, 1'b0);
        // new_game mid-frame, held long
        wait_phase(4'b0000, 50);
        repeat (500) cycle(4'b0001, 1'b0);
        repeat (50) cycle(4'b0000, 1'b0);
        // new_game acceptance landing on the frame wrap edge
        wait_phase(4'b0000, FC - 9);
        repeat (250) cycle(4'b0001, 1'b0);
        repeat (50) cycle(4'b0000, 1'b0);
        // reset while hit is held mid-frame
        repeat (250) cycle(4'b0010, 1'b0);
        wait_phase(4'b0010, 40);
        cycle(4'b0010, 1'b1);
        repeat (300) cycle(4'b0010, 1'b0);
        // random button activity with occasional resets
        repeat (200) begin
            b    = 4'($urandom_range(15, 0));
            hold = $urandom_range(25, 1);
            if ($urandom_range(39, 0) == 0) cycle(b, 1'b1);
            repeat (hold) cycle(b, 1'b0);
        end
        repeat (2) cycle(4'b0000, 1'b1);
        @(negedge clk_in);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL leftover_events got %0d pending want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
